fifo_hs_reader: RTL and testbench
=================================

Name: fifo_hs_reader

Overview:
- Ring-buffer FIFO with a valid/ready handshake on both ends. It is the consumer-facing counterpart to the team's shift-enable delay FIFOs.
- The producer (systolic-array result path or MMIO write path) pushes words. A downstream reader (MMIO read mux or CCI-P write-back) pops them at its own pace.
- First-word-fall-through: the head entry is always presented on q when out_valid=1.
- Provides occupancy count, almost-full indication and synchronous flush.

Parameters:
- DEPTH, 8, number of entries; must be a power of 2 and >= 2.
- BITS, 64, data word width.
- AFULL_LVL, 6, almost_full asserts when count >= AFULL_LVL; legal range 1..DEPTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush; empties FIFO
- in_valid  in  1  producer has word on d
- in_ready  out  1  FIFO can accept; equals !full
- d  in  BITS  write data
- out_valid  out  1  head word valid on q; equals !empty
- out_ready  in  1  reader accepts head word
- q  out  BITS  head word (FWFT)
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- almost_full  out  1  count >= AFULL_LVL

Behaviour:
- Reset (rst_n=0, asynchronous), effective immediately:
  - wr_ptr=0, rd_ptr=0, count=0.
  - in_ready=1, out_valid=0, almost_full=0.
  - All storage entries cleared to 0, so q=0.
- clr=1 at a clock edge:
  - Same register values as reset (pointers, count and storage all zeroed).
  - Has priority over push and pop in the same cycle; both are discarded.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready depends only on full. It has no combinational path from out_ready: push into a full FIFO is refused even if a pop occurs in the same cycle.
- Push: mem[wr_ptr] <= d; wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH. The popped entry is not cleared.
- Count update per cycle: +1 for push only, -1 for pop only, unchanged for both or neither.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from count, not from pointer compare.
- Latency:
  - A word pushed into an empty FIFO appears on q with out_valid=1 in the cycle after the push edge.
  - After a pop, the next entry appears on q in the cycle after the pop edge.
- q is a combinational read of mem[rd_ptr].
  - q is stable while out_valid=1 and out_ready=0.
  - q is don't-care when out_valid=0, except after reset or clr, when it reads 0.
- Empty with in_valid=1 and out_ready=1: the push is accepted, there is no pop, and count goes 0 -> 1.
- Full with in_valid=1 and out_ready=1: only the pop occurs, and count goes DEPTH -> DEPTH-1.
- Outputs in_ready, out_valid, count and almost_full are all derived from registered count; none is combinational from an input.
- Asserting rst_n mid-stream discards all contents; there is no partial-state retention.

Decomposition:
- fifo_pkg:
  - function ptr_w(depth) returning $clog2(depth).
  - localparam-style helper for count width.
  - Shared with the team's delay FIFOs.
- No sub-module required; pointer/count logic is inline.
- Optional sub-module fifo_hs_ctrl (pointers, count, flags) if the storage is later swapped for a RAM macro.

Test Plan:
- Reset/flush check:
  - Stimulus: apply rst_n=0, release, hold all inputs idle.
  - Required: count=0, in_ready=1, out_valid=0, q=0.
  - Then push 3 words and pulse clr. Required: count=0 and out_valid=0 on the next cycle.
- Fill/drain ordering:
  - Stimulus: push 0x11..0x88 (8 words) with out_ready=0.
  - Required after the 8th push: count=8, in_ready=0, almost_full=1 (from the 6th push onward).
  - Then drain with out_ready=1. Required: q sequence 0x11,0x22,...,0x88, and out_valid=0 afterward.
- Full boundary:
  - Stimulus: FIFO full, in_valid=1 with d=0x99, out_ready=1 for one cycle.
  - Required: 0x11 is popped, 0x99 is not stored, count=7, in_ready=1 on the next cycle.
- Empty boundary:
  - Stimulus: FIFO empty, in_valid=1 with d=0xAA, out_ready=1.
  - Required: count=1; q=0xAA with out_valid=1 the next cycle; no pop is recorded.
- Wrap-around throughput:
  - Stimulus: 20 consecutive words 0..19 pushed with out_ready=1 every cycle.
  - Required: count stays at 1 in steady state; q outputs 0..19 in order with no gaps after the first cycle; pointers wrap twice.
- Backpressure stability and reset mid-stream:
  - Stimulus: out_ready toggled 1,0,0,1 while out_valid=1.
  - Required: q is held constant during the stall cycles.
  - Then assert rst_n low mid-burst. Required: immediate count=0 and out_valid=0, and no stale data after release.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the handshake FIFO and the delay FIFOs.
package fifo_pkg;

    // Width of a read/write pointer into a power-of-two ring buffer.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_hs_reader.sv
// Ring-buffer FIFO with valid/ready handshake on both ports, first-word-fall-through
// head on q, occupancy count, almost-full flag and synchronous flush.
module fifo_hs_reader
    import fifo_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int BITS      = 64,
    parameter int AFULL_LVL = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BITS-1:0]           d,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BITS-1:0]           q,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      almost_full
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [BITS-1:0] mem_q [DEPTH];
    logic [BITS-1:0] mem_d [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Status flags come only from the registered count, never from the inputs.
    always_comb begin
        full        = (count_q == CW'(DEPTH));
        empty       = (count_q == '0);
        in_ready    = !full;
        out_valid   = !empty;
        almost_full = (count_q >= CW'(AFULL_LVL));
        count       = count_q;
        q           = mem_q[rd_ptr_q];
        push        = in_valid && !full;
        pop         = out_ready && !empty;
    end

    // Next-state for pointers, count and storage; flush overrides push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            mem_d    = '{default: '0};
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = d;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset clears storage too so q reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_fifo_hs_reader.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_fifo_hs_reader;

    localparam int DEPTH = 8;
    localparam int BITS  = 64;
    localparam int AFL   = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            clr = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [BITS-1:0] d = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [BITS-1:0] q;
    logic [3:0]      count;
    logic            almost_full;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit check_en = 1'b0;

    logic [BITS-1:0] mq[$];
    bit              mzero = 1'b1;
    bit              mpush, mpop;
    logic [BITS-1:0] pops[$];
    logic [BITS-1:0] held;

    fifo_hs_reader #(.DEPTH(DEPTH), .BITS(BITS), .AFULL_LVL(AFL)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .d(d),
        .out_valid(out_valid), .out_ready(out_ready), .q(q),
        .count(count), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain queue of accepted words.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mzero = 1'b1;
        end else if (clr) begin
            mq.delete();
            mzero = 1'b1;
        end else begin
            mpush = in_valid && (mq.size() < DEPTH);
            mpop  = out_ready && (mq.size() > 0);
            if (mpop) void'(mq.pop_front());
            if (mpush) begin
                mq.push_back(d);
                mzero = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of words actually popped.
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_count", 64'(count), 64'(mq.size()));
            chk("m_out_valid", 64'(out_valid), 64'(mq.size() != 0));
            chk("m_in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
            chk("m_almost_full", 64'(almost_full), 64'(mq.size() >= AFL));
            if (mq.size() != 0) chk("m_q_head", q, mq[0]);
            else if (mzero) chk("m_q_zero", q, 64'h0);
            if (out_valid && out_ready && rst_n && !clr) pops.push_back(q);
        end
    end

    initial begin
        // Reset and idle
        #2 rst_n = 1'b0;
        check_en = 1'b1;
        repeat (3) tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_q", q, 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_count", 64'(count), 64'd0);
        chk("idle_q", q, 64'd0);

        // Push three words then flush, with a competing push and pop on the flush cycle
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            d = 64'(i);
            tick();
        end
        chk("pre_clr_count", 64'(count), 64'd3);
        clr = 1'b1; d = 64'hDEAD; out_ready = 1'b1;
        tick();
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_out_valid", 64'(out_valid), 64'd0);
        chk("clr_q", q, 64'd0);
        tick();
        chk("clr_hold_count", 64'(count), 64'd0);
        pops.delete();

        // Fill with 0x11..0x88, no reads
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            d = 64'(i * 'h11);
            tick();
            if (i == 5) chk("afull_at5", 64'(almost_full), 64'd0);
            if (i == 6) chk("afull_at6", 64'(almost_full), 64'd1);
        end
        chk("full_count", 64'(count), 64'd8);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_afull", 64'(almost_full), 64'd1);
        chk("full_q", q, 64'h11);

        // Full boundary: push refused, pop happens
        in_valid = 1'b1; d = 64'h99; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("fb_count", 64'(count), 64'd7);
        chk("fb_in_ready", 64'(in_ready), 64'd1);
        chk("fb_q", q, 64'h22);

        // Drain the rest
        repeat (7) tick();
        out_ready = 1'b0;
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("drain_npops", 64'(pops.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            if (i < pops.size()) chk("drain_seq", pops[i], 64'((i + 1) * 'h11));
        pops.delete();

        // Empty boundary: push accepted, no pop
        in_valid = 1'b1; d = 64'hAA; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("eb_count", 64'(count), 64'd1);
        chk("eb_q", q, 64'hAA);
        chk("eb_out_valid", 64'(out_valid), 64'd1);
        chk("eb_no_pop", 64'(pops.size()), 64'd0);
        tick();
        out_ready = 1'b0;
        chk("eb_drained", 64'(count), 64'd0);
        pops.delete();

        // Streaming with simultaneous push/pop across pointer wrap
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            d = 64'(i);
            tick();
            chk("wrap_count", 64'(count), 64'd1);
            chk("wrap_q", q, 64'(i));
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("wrap_npops", 64'(pops.size()), 64'd20);
        for (int i = 0; i < 20; i++)
            if (i < pops.size()) chk("wrap_seq", pops[i], 64'(i));
        pops.delete();

        // Backpressure: q must hold while stalled
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            d = 64'('hA0 + i);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_q0", q, 64'hA1);
        tick();
        out_ready = 1'b0;
        chk("bp_q1", q, 64'hA2);
        held = q;
        tick();
        chk("bp_q2_held", q, held);
        tick();
        chk("bp_q3_held", q, 64'hA2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_after", q, 64'hA3);

        // Asynchronous reset in the middle of a burst
        in_valid = 1'b1;
        d = 64'h55;
        tick();
        d = 64'h66;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_q", q, 64'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_q", q, 64'd0);
        in_valid = 1'b1; d = 64'h77;
        tick();
        in_valid = 1'b0;
        chk("post_rst_push_q", q, 64'h77);
        chk("post_rst_push_count", 64'(count), 64'd1);
        tick();

        check_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
